// File: rtl/maze_pkg.sv
`default_nettype none
// maze_pkg: shared state encoding, field widths and game defaults for the maze sequencer.
// Rev 1.0
package maze_pkg;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_LOAD    = 3'd1;
  localparam logic [2:0] ST_PLAY    = 3'd2;
  localparam logic [2:0] ST_RESPAWN = 3'd3;
  localparam logic [2:0] ST_WIN     = 3'd4;
  localparam logic [2:0] ST_OVER    = 3'd5;

  typedef enum logic [2:0] {
    IDLE    = ST_IDLE,
    LOAD    = ST_LOAD,
    PLAY    = ST_PLAY,
    RESPAWN = ST_RESPAWN,
    WIN     = ST_WIN,
    OVER    = ST_OVER
  } state_t;

  localparam int LIVES_W = 2;
  localparam int SECS_W  = 7;

  localparam int DEF_LIVES      = 3;
  localparam int DEF_TIME_LIMIT = 60;
  localparam int DEF_NUM_LEVELS = 2;

endpackage
`default_nettype wire

// File: rtl/btn_sync_edge.sv
`default_nettype none
// btn_sync_edge: 2-FF synchroniser for an asynchronous button plus a 1-clk rising-edge pulse.
// Rev 1.0
module btn_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic btn,
  output logic pulse
);

  // sync[0..1] resynchronise; sync[2] remembers the previous synchronised level
  logic [2:0] sync;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync <= '0;
    end else begin
      sync <= {sync[1:0], btn};
    end
  end

  assign pulse = sync[1] & ~sync[2];

endmodule
`default_nettype wire

// File: rtl/maze_game_sequencer.sv
`default_nettype none
// maze_game_sequencer: game-flow FSM owning lives, per-level countdown and level index.
// Rev 1.0
module maze_game_sequencer
  import maze_pkg::*;
#(
  parameter int LIVES         = DEF_LIVES,
  parameter int TIME_LIMIT    = DEF_TIME_LIMIT,
  parameter int TICKS_PER_SEC = 60,
  parameter int FREEZE_FRAMES = 30,
  parameter int NUM_LEVELS    = DEF_NUM_LEVELS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               update,
  input  logic               start_btn,
  input  logic               levelselect,
  input  logic               wall_hit,
  input  logic               goal_reached,
  output logic               level,
  output logic               play_en,
  output logic               player_rst,
  output logic [LIVES_W-1:0] lives,
  output logic [SECS_W-1:0]  secs_left,
  output logic               show_win,
  output logic               show_over
);

  localparam int TICK_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam int FRZ_W  = (FREEZE_FRAMES > 0) ? $clog2(FREEZE_FRAMES + 1) : 1;

  state_t              state, state_d;
  logic [TICK_W-1:0]   tick, tick_d;
  logic [FRZ_W-1:0]    frz, frz_d;
  logic                level_d;
  logic [LIVES_W-1:0]  lives_d;
  logic [SECS_W-1:0]   secs_d;
  logic                prst_d;
  logic                start_p;

  btn_sync_edge u_start (
    .clk   (clk),
    .rst   (rst),
    .btn   (start_btn),
    .pulse (start_p)
  );

  always_comb begin
    state_d = state;
    level_d = level;
    lives_d = lives;
    secs_d  = secs_left;
    tick_d  = '0;
    frz_d   = frz;
    prst_d  = 1'b0;

    case (state)
      IDLE: begin
        level_d = levelselect;
        if (start_p) begin
          lives_d = LIVES_W'(LIVES);
          state_d = LOAD;
        end
      end

      LOAD: begin
        prst_d  = 1'b1;
        secs_d  = SECS_W'(TIME_LIMIT);
        state_d = PLAY;
      end

      PLAY: begin
        tick_d = tick;
        if (goal_reached) begin
          tick_d  = '0;
          state_d = WIN;
        end else if (wall_hit || (secs_left == '0)) begin
          tick_d  = '0;
          if (secs_left == '0) begin
            secs_d = SECS_W'(TIME_LIMIT);
          end
          if (lives == LIVES_W'(1)) begin
            lives_d = '0;
            state_d = OVER;
          end else begin
            lives_d = lives - LIVES_W'(1);
            prst_d  = 1'b1;
            frz_d   = FRZ_W'(FREEZE_FRAMES);
            state_d = RESPAWN;
          end
        end else if (update) begin
          if (tick == TICK_W'(TICKS_PER_SEC - 1)) begin
            tick_d = '0;
            if (secs_left != '0) begin
              secs_d = secs_left - SECS_W'(1);
            end
          end else begin
            tick_d = tick + TICK_W'(1);
          end
        end
      end

      RESPAWN: begin
        if (update) begin
          // a zero or one count both release on this update
          if (frz <= FRZ_W'(1)) begin
            frz_d   = '0;
            state_d = PLAY;
          end else begin
            frz_d = frz - FRZ_W'(1);
          end
        end
      end

      WIN: begin
        if (start_p) begin
          if (int'(level) < NUM_LEVELS - 1) begin
            level_d = level + 1'b1;
            state_d = LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end

      OVER: begin
        if (start_p) begin
          level_d = levelselect;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      level      <= 1'b0;
      lives      <= LIVES_W'(LIVES);
      secs_left  <= SECS_W'(TIME_LIMIT);
      tick       <= '0;
      frz        <= '0;
      player_rst <= 1'b0;
      play_en    <= 1'b0;
      show_win   <= 1'b0;
      show_over  <= 1'b0;
    end else begin
      state      <= state_d;
      level      <= level_d;
      lives      <= lives_d;
      secs_left  <= secs_d;
      tick       <= tick_d;
      frz        <= frz_d;
      player_rst <= prst_d;
      play_en    <= (state_d == PLAY);
      show_win   <= (state_d == WIN);
      show_over  <= (state_d == OVER);
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_maze_game_sequencer.sv
`default_nettype none
// tb_maze_game_sequencer: directed scenarios plus random play checked against a game-rule model.
// Rev 1.0
module tb_maze_game_sequencer;

  localparam int LIVES = 3;
  localparam int TL    = 3;
  localparam int TPS   = 4;
  localparam int FF    = 2;
  localparam int NL    = 2;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       update = 1'b0, start_btn = 1'b0, levelselect = 1'b0;
  logic       wall_hit = 1'b0, goal_reached = 1'b0;
  logic       level, play_en, player_rst, show_win, show_over;
  logic [1:0] lives;
  logic [6:0] secs_left;

  int checks   = 0;
  int failures = 0;

  maze_game_sequencer #(
    .LIVES(LIVES), .TIME_LIMIT(TL), .TICKS_PER_SEC(TPS),
    .FREEZE_FRAMES(FF), .NUM_LEVELS(NL)
  ) dut (
    .clk(clk), .rst(rst), .update(update), .start_btn(start_btn),
    .levelselect(levelselect), .wall_hit(wall_hit), .goal_reached(goal_reached),
    .level(level), .play_en(play_en), .player_rst(player_rst), .lives(lives),
    .secs_left(secs_left), .show_win(show_win), .show_over(show_over)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d @%0t", tag, got, exp, $time);
    end
  endtask

  // Game model: phase of play, lives, whole seconds left, frames into the current second.
  typedef enum {M_IDLE, M_LOAD, M_PLAY, M_RESP, M_WIN, M_OVER} phase_t;
  phase_t ph;
  int  m_level, m_lives, m_secs, m_frames, m_freeze;
  bit  m_prst;
  bit  btn_hist[3];

  task automatic model_reset();
    ph = M_IDLE; m_level = 0; m_lives = LIVES; m_secs = TL;
    m_frames = 0; m_freeze = 0; m_prst = 0;
    btn_hist = '{0, 0, 0};
  endtask

  task automatic lose_life();
    if (m_secs == 0) m_secs = TL;
    m_lives = m_lives - 1;
    m_frames = 0;
    if (m_lives == 0) ph = M_OVER;
    else begin
      m_prst = 1; m_freeze = FF; ph = M_RESP;
    end
  endtask

  task automatic model_step();
    bit press;
    // the button is seen two clocks late; a press is a newly seen high level
    press = btn_hist[1] && !btn_hist[2];
    btn_hist[2] = btn_hist[1]; btn_hist[1] = btn_hist[0]; btn_hist[0] = start_btn;
    m_prst = 0;
    case (ph)
      M_IDLE: begin
        m_level = levelselect;
        if (press) begin m_lives = LIVES; ph = M_LOAD; end
      end
      M_LOAD: begin m_prst = 1; m_secs = TL; m_frames = 0; ph = M_PLAY; end
      M_PLAY: begin
        if (goal_reached) begin m_frames = 0; ph = M_WIN; end
        else if (wall_hit || m_secs == 0) lose_life();
        else if (update) begin
          m_frames++;
          if (m_frames == TPS) begin
            m_frames = 0;
            if (m_secs > 0) m_secs--;
          end
        end
      end
      M_RESP: if (update) begin
        m_freeze--;
        if (m_freeze <= 0) begin m_freeze = 0; ph = M_PLAY; end
      end
      M_WIN: if (press) begin
        if (m_level < NL - 1) begin m_level++; ph = M_LOAD; end
        else ph = M_IDLE;
      end
      M_OVER: if (press) begin m_level = levelselect; ph = M_IDLE; end
      default: ph = M_IDLE;
    endcase
  endtask

  task automatic compare_all();
    check_eq("level",      32'(level),      32'(m_level));
    check_eq("play_en",    32'(play_en),    32'(ph == M_PLAY));
    check_eq("player_rst", 32'(player_rst), 32'(m_prst));
    check_eq("lives",      32'(lives),      32'(m_lives));
    check_eq("secs_left",  32'(secs_left),  32'(m_secs));
    check_eq("show_win",   32'(show_win),   32'(ph == M_WIN));
    check_eq("show_over",  32'(show_over),  32'(ph == M_OVER));
  endtask

  task automatic cycle();
    @(posedge clk);
    if (rst) model_step();
    @(negedge clk);
    compare_all();
  endtask

  task automatic pulse_updates(input int n);
    for (int i = 0; i < n; i++) begin
      update = 1'b1; cycle();
      update = 1'b0; cycle();
    end
  endtask

  task automatic press_start();
    start_btn = 1'b1; repeat (4) cycle();
    start_btn = 1'b0; repeat (2) cycle();
  endtask

  task automatic async_reset_check(input string tag);
    rst = 1'b0;
    #1;
    model_reset();
    check_eq({tag, "_lives"},  32'(lives), LIVES);
    check_eq({tag, "_secs"},   32'(secs_left), TL);
    check_eq({tag, "_play"},   32'(play_en), 0);
    check_eq({tag, "_level"},  32'(level), 0);
    check_eq({tag, "_win"},    32'(show_win), 0);
    check_eq({tag, "_over"},   32'(show_over), 0);
    check_eq({tag, "_prst"},   32'(player_rst), 0);
  endtask

  initial begin
    model_reset();
    levelselect = 1'b1;
    repeat (2) @(negedge clk);
    async_reset_check("reset");
    rst = 1'b1;
    cycle();

    // start with levelselect=1
    start_btn = 1'b1;
    repeat (4) cycle();
    check_eq("start_level", 32'(level), 1);
    check_eq("start_play",  32'(play_en), 1);
    check_eq("start_lives", 32'(lives), LIVES);
    check_eq("start_secs",  32'(secs_left), TL);
    start_btn = 1'b0;
    cycle();

    // countdown to timeout
    pulse_updates(4);
    check_eq("secs_after_1s", 32'(secs_left), TL - 1);
    pulse_updates(7);
    update = 1'b1; cycle(); update = 1'b0;
    check_eq("secs_zero", 32'(secs_left), 0);
    check_eq("lives_before_timeout", 32'(lives), 3);
    cycle();
    check_eq("timeout_lives", 32'(lives), 2);
    check_eq("timeout_prst",  32'(player_rst), 1);
    check_eq("timeout_play",  32'(play_en), 0);
    check_eq("timeout_reload", 32'(secs_left), TL);
    pulse_updates(2);
    check_eq("unfreeze_play", 32'(play_en), 1);

    // wall held into the freeze costs only one life
    wall_hit = 1'b1; cycle();
    check_eq("wall_lives", 32'(lives), 1);
    check_eq("wall_play",  32'(play_en), 0);
    update = 1'b1; cycle(); update = 1'b0; wall_hit = 1'b0; cycle();
    pulse_updates(1);
    check_eq("freeze_lives", 32'(lives), 1);
    check_eq("freeze_play",  32'(play_en), 1);

    // goal wins over a simultaneous wall hit
    goal_reached = 1'b1; wall_hit = 1'b1; cycle();
    goal_reached = 1'b0; wall_hit = 1'b0;
    check_eq("simul_win",   32'(show_win), 1);
    check_eq("simul_lives", 32'(lives), 1);

    // win on the last level returns to idle
    levelselect = 1'b0;
    press_start();
    check_eq("lastwin_show", 32'(show_win), 0);
    check_eq("lastwin_play", 32'(play_en), 0);

    // level advance keeps lives
    press_start();
    wall_hit = 1'b1; cycle(); wall_hit = 1'b0;
    pulse_updates(2);
    goal_reached = 1'b1; cycle(); goal_reached = 1'b0;
    press_start();
    check_eq("adv_level", 32'(level), 1);
    check_eq("adv_lives", 32'(lives), 2);
    check_eq("adv_play",  32'(play_en), 1);

    // run out of lives
    for (int i = 0; i < 2; i++) begin
      wall_hit = 1'b1; cycle(); wall_hit = 1'b0;
      pulse_updates(2);
    end
    check_eq("over_lives", 32'(lives), 0);
    check_eq("over_show",  32'(show_over), 1);
    check_eq("over_play",  32'(play_en), 0);

    // mid-play asynchronous reset
    levelselect = 1'b1;
    press_start();
    press_start();
    pulse_updates(3);
    async_reset_check("midreset");
    cycle();
    rst = 1'b1;
    cycle();

    // random play
    for (int n = 0; n < 3000; n++) begin
      update       = ($urandom_range(0, 2) == 0);
      wall_hit     = ($urandom_range(0, 24) == 0);
      goal_reached = ($urandom_range(0, 39) == 0);
      if ($urandom_range(0, 11) == 0) start_btn = ~start_btn;
      if ($urandom_range(0, 7) == 0) levelselect = ~levelselect;
      if ($urandom_range(0, 799) == 0) begin
        async_reset_check("rand_reset");
        cycle();
        rst = 1'b1;
      end
      cycle();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
